// File: rtl/tron_pkg.sv
// Shared types and constants for the Tron match sequencer.
// State codes are fixed because the score block decodes Game_State directly.
package tron_pkg;

    typedef enum logic [2:0] {
        ST_TITLE     = 3'd0,
        ST_NEW_GAME  = 3'd1,
        ST_PLAY      = 3'd2,
        ST_ROUND_END = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_t;

    localparam int PAUSE_FRAMES_DEF     = 120;
    localparam int OVER_HOLD_FRAMES_DEF = 60;
    localparam int CNT_W_DEF            = 8;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_BLUE = 2'b01;
    localparam logic [1:0] WINNER_RED  = 2'b10;

    // Blue takes priority when both players reach the winning score together.
    function automatic logic [1:0] winner_code(input logic blue_w, input logic red_w);
        return {red_w & ~blue_w, blue_w};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// The tick is a single-cycle pulse three clock edges after the source rises.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic tick
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            tick   <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
            tick   <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Tron match sequencer: title, rounds, inter-round pause and game-over hold.
// Drives the score block through Game_State/Reset_Score and latches the winner.
module game_state_ctrl
    import tron_pkg::*;
#(
    parameter int PAUSE_FRAMES     = PAUSE_FRAMES_DEF,
    parameter int OVER_HOLD_FRAMES = OVER_HOLD_FRAMES_DEF,
    parameter int CNT_W            = CNT_W_DEF
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       start_key,
    input  logic       collision_blue,
    input  logic       collision_red,
    input  logic       collision_blue_trail,
    input  logic       collision_red_trail,
    input  logic       Blue_W,
    input  logic       Red_W,
    output logic [2:0] Game_State,
    output logic       Reset_Score,
    output logic       reset_round,
    output logic       play_en,
    output logic [1:0] winner
);

    localparam logic [CNT_W-1:0] PAUSE_CNT = CNT_W'(PAUSE_FRAMES);
    localparam logic [CNT_W-1:0] HOLD_CNT  = CNT_W'(OVER_HOLD_FRAMES);

    logic             frame_tick;
    logic             start_tick;
    logic             any_collision;
    logic             frame_advance;
    game_state_t      state;
    game_state_t      next_state;
    logic [CNT_W-1:0] cnt;

    sync_edge u_frame_sync (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .async_in (frame_clk),
        .tick     (frame_tick)
    );

    sync_edge u_start_sync (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .async_in (start_key),
        .tick     (start_tick)
    );

    assign any_collision = collision_blue | collision_red |
                           collision_blue_trail | collision_red_trail;

    // The game-over counter stops at the hold limit; the pause counter never
    // passes its limit because reaching it forces a state exit.
    assign frame_advance = frame_tick &&
                           ((state == ST_ROUND_END) ||
                            (state == ST_GAME_OVER && cnt != HOLD_CNT));

    assign Game_State = state;

    always_comb begin
        next_state = state;
        case (state)
            ST_TITLE:     if (start_tick) next_state = ST_NEW_GAME;
            ST_NEW_GAME:  next_state = ST_PLAY;
            ST_PLAY:      if (any_collision) next_state = ST_ROUND_END;
            ST_ROUND_END: begin
                if (cnt == PAUSE_CNT)
                    next_state = (Blue_W | Red_W) ? ST_GAME_OVER : ST_PLAY;
            end
            ST_GAME_OVER: if (start_tick && cnt == HOLD_CNT) next_state = ST_NEW_GAME;
            default:      next_state = ST_TITLE;
        endcase
    end

    // Outputs are computed from next_state so they line up with the state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_TITLE;
            cnt         <= '0;
            Reset_Score <= 1'b1;
            reset_round <= 1'b0;
            play_en     <= 1'b0;
            winner      <= WINNER_NONE;
        end else begin
            state <= next_state;

            if (next_state != state)
                cnt <= '0;
            else if (frame_advance)
                cnt <= cnt + 1'b1;

            Reset_Score <= (next_state == ST_TITLE);
            play_en     <= (next_state == ST_PLAY);
            reset_round <= (next_state == ST_PLAY) && (state != ST_PLAY);

            if (next_state == ST_GAME_OVER) begin
                if (state != ST_GAME_OVER)
                    winner <= winner_code(Blue_W, Red_W);
            end else begin
                winner <= WINNER_NONE;
            end
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl with short pause/hold parameters.
// Randomised collision lines and win inputs are checked against a rule-level model.
module tb_game_state_ctrl;

    localparam int PAUSE = 4;
    localparam int HOLD  = 3;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       start_key = 1'b0;
    logic       collision_blue = 1'b0;
    logic       collision_red = 1'b0;
    logic       collision_blue_trail = 1'b0;
    logic       collision_red_trail = 1'b0;
    logic       Blue_W = 1'b0;
    logic       Red_W = 1'b0;
    logic [2:0] Game_State;
    logic       Reset_Score;
    logic       reset_round;
    logic       play_en;
    logic [1:0] winner;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    game_state_ctrl #(
        .PAUSE_FRAMES     (PAUSE),
        .OVER_HOLD_FRAMES (HOLD),
        .CNT_W            (8)
    ) dut (
        .Clk                  (Clk),
        .Reset_n              (Reset_n),
        .frame_clk            (frame_clk),
        .start_key            (start_key),
        .collision_blue       (collision_blue),
        .collision_red        (collision_red),
        .collision_blue_trail (collision_blue_trail),
        .collision_red_trail  (collision_red_trail),
        .Blue_W               (Blue_W),
        .Red_W                (Red_W),
        .Game_State           (Game_State),
        .Reset_Score          (Reset_Score),
        .reset_round          (reset_round),
        .play_en              (play_en),
        .winner               (winner)
    );

    // Rule-level model: after the pause, any win ends the match; blue wins ties.
    function automatic logic [2:0] model_after_pause(input logic bw, input logic rw);
        return (bw | rw) ? 3'd4 : 3'd2;
    endfunction

    function automatic logic [1:0] model_winner(input logic bw, input logic rw);
        if (bw) return 2'b01;
        if (rw) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_collisions(input logic [3:0] v);
        {collision_blue, collision_red, collision_blue_trail, collision_red_trail} = v;
    endtask

    task automatic frame_edge();
        frame_clk = 1'b0;
        step(6);
        frame_clk = 1'b1;
        step(6);
    endtask

    // Press start from state 'from' and follow NEW_GAME -> PLAY; optionally keep the key held.
    task automatic start_game(input logic [2:0] from, input int hold);
        int k;
        int dev;
        k = 0;
        start_key = 1'b1;
        while (Game_State == from && k < 12) begin
            step(1);
            k++;
        end
        n_cmp++; if (Game_State !== 3'd1) begin n_bad++; $display("FAIL new_game_state: got %0d want 1", Game_State); end
        n_cmp++; if (winner !== 2'b00) begin n_bad++; $display("FAIL new_game_winner: got %b want 00", winner); end
        n_cmp++; if (Reset_Score !== 1'b0) begin n_bad++; $display("FAIL new_game_reset_score: got %b want 0", Reset_Score); end
        step(1);
        n_cmp++; if (Game_State !== 3'd2) begin n_bad++; $display("FAIL play_entry_state: got %0d want 2", Game_State); end
        n_cmp++; if (reset_round !== 1'b1) begin n_bad++; $display("FAIL play_entry_reset_round: got %b want 1", reset_round); end
        n_cmp++; if (play_en !== 1'b1) begin n_bad++; $display("FAIL play_entry_play_en: got %b want 1", play_en); end
        step(1);
        n_cmp++; if (reset_round !== 1'b0) begin n_bad++; $display("FAIL reset_round_width: got %b want 0", reset_round); end
        dev = 0;
        for (int i = 0; i < hold; i++) begin
            step(1);
            if (Game_State !== 3'd2 && dev == 0) dev = i + 1;
        end
        if (hold > 0) begin
            n_cmp++; if (dev != 0) begin n_bad++; $display("FAIL held_key_stable: left PLAY at held cycle %0d want never", dev); end
        end
        start_key = 1'b0;
        step(2);
    endtask

    // One round from PLAY: collide, pause PAUSE frames, check the outcome against the model.
    task automatic play_round(input logic bw_final, input logic rw_final, input logic hold_coll);
        logic [3:0] line;
        logic [2:0] exp_state;
        int k;
        line = 4'b0001 << $urandom_range(0, 3);
        set_collisions(line);
        step(1);
        n_cmp++; if (Game_State !== 3'd3) begin n_bad++; $display("FAIL collision_to_round_end: got %0d want 3 (line %b)", Game_State, line); end
        n_cmp++; if (play_en !== 1'b0) begin n_bad++; $display("FAIL round_end_play_en: got %b want 0", play_en); end
        if (!hold_coll) set_collisions(4'b0000);
        for (int i = 0; i < PAUSE - 1; i++) begin
            Blue_W = 1'($urandom);
            Red_W  = 1'($urandom);
            frame_edge();
            n_cmp++; if (Game_State !== 3'd3) begin n_bad++; $display("FAIL pause_frame_%0d: got %0d want 3", i + 1, Game_State); end
        end
        set_collisions(4'b0000);
        Blue_W = bw_final;
        Red_W  = rw_final;
        frame_clk = 1'b0;
        step(6);
        frame_clk = 1'b1;
        k = 0;
        while (Game_State == 3'd3 && k < 12) begin
            step(1);
            k++;
        end
        exp_state = model_after_pause(bw_final, rw_final);
        n_cmp++; if (Game_State !== exp_state) begin n_bad++; $display("FAIL pause_expiry: got %0d want %0d (bw %b rw %b)", Game_State, exp_state, bw_final, rw_final); end
        if (exp_state == 3'd2) begin
            n_cmp++; if (reset_round !== 1'b1) begin n_bad++; $display("FAIL new_round_reset_round: got %b want 1", reset_round); end
        end else begin
            n_cmp++; if (winner !== model_winner(bw_final, rw_final)) begin n_bad++; $display("FAIL winner: got %b want %b", winner, model_winner(bw_final, rw_final)); end
            n_cmp++; if (play_en !== 1'b0) begin n_bad++; $display("FAIL game_over_play_en: got %b want 0", play_en); end
        end
        Blue_W = 1'b0;
        Red_W  = 1'b0;
    endtask

    // Sit in GAME_OVER: early start press and held collisions must not move it.
    task automatic game_over_hold(input logic [1:0] exp_winner);
        set_collisions(4'b1111);
        for (int i = 0; i < HOLD - 1; i++) frame_edge();
        start_key = 1'b1;
        step(10);
        start_key = 1'b0;
        step(4);
        n_cmp++; if (Game_State !== 3'd4) begin n_bad++; $display("FAIL early_start_ignored: got %0d want 4", Game_State); end
        frame_edge();
        n_cmp++; if (Game_State !== 3'd4) begin n_bad++; $display("FAIL collisions_in_game_over: got %0d want 4", Game_State); end
        n_cmp++; if (winner !== exp_winner) begin n_bad++; $display("FAIL winner_hold: got %b want %b", winner, exp_winner); end
        set_collisions(4'b0000);
        start_game(3'd4, 0);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        step(3);
        n_cmp++; if (Game_State !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", Game_State); end
        n_cmp++; if (Reset_Score !== 1'b1) begin n_bad++; $display("FAIL reset_score: got %b want 1", Reset_Score); end
        n_cmp++; if (reset_round !== 1'b0) begin n_bad++; $display("FAIL reset_round: got %b want 0", reset_round); end
        n_cmp++; if (play_en !== 1'b0) begin n_bad++; $display("FAIL reset_play_en: got %b want 0", play_en); end
        n_cmp++; if (winner !== 2'b00) begin n_bad++; $display("FAIL reset_winner: got %b want 00", winner); end
        Reset_n = 1'b1;
        set_collisions(4'b1111);
        frame_edge();
        step(10);
        n_cmp++; if (Game_State !== 3'd0) begin n_bad++; $display("FAIL idle_title: got %0d want 0", Game_State); end
        n_cmp++; if (Reset_Score !== 1'b1) begin n_bad++; $display("FAIL idle_reset_score: got %b want 1", Reset_Score); end
        set_collisions(4'b0000);
    endtask

    task automatic test_start();
        start_game(3'd0, 1000);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) play_round(1'b0, 1'b0, 1'($urandom));
    endtask

    task automatic test_red_wins();
        play_round(1'b0, 1'b1, 1'b0);
        game_over_hold(2'b10);
    endtask

    task automatic test_both_win();
        play_round(1'b1, 1'b1, 1'b1);
        game_over_hold(2'b01);
    endtask

    task automatic test_reset_mid_round();
        set_collisions(4'b0001 << $urandom_range(0, 3));
        step(1);
        set_collisions(4'b0000);
        frame_edge();
        frame_edge();
        n_cmp++; if (Game_State !== 3'd3) begin n_bad++; $display("FAIL pre_reset_round_end: got %0d want 3", Game_State); end
        #2;
        Reset_n = 1'b0;
        #1;
        n_cmp++; if (Game_State !== 3'd0) begin n_bad++; $display("FAIL async_reset_state: got %0d want 0", Game_State); end
        n_cmp++; if (Reset_Score !== 1'b1 || play_en !== 1'b0 || reset_round !== 1'b0 || winner !== 2'b00) begin
            n_bad++; $display("FAIL async_reset_outputs: got rs %b pe %b rr %b w %b want 1 0 0 00", Reset_Score, play_en, reset_round, winner);
        end
        #2;
        Reset_n = 1'b1;
        step(3);
        start_game(3'd0, 0);
        play_round(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_start();
        test_back_to_back();
        test_red_wins();
        test_both_win();
        test_reset_mid_round();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

endmodule
